// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the RV32I memory-access stage.
//   - state_e      : transaction FSM states (IDLE / REQ / WAIT)
//   - F3_*         : RV32I load/store funct3 encodings
//   - SZ_*         : access-size code carried in funct3[1:0]
//   - CAUSE_*      : M_fault_cause encodings
//   - byte_en()    : byte-enable mask for a given size and address offset
//   - store_lanes(): lane-replicated store data for a given size
//   - misaligned() : natural-alignment violation check (used only when
//                    MEM_STAGE_MISALIGN_TRAP_EN is defined)
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

  // Low address bits below the access width are ignored here, so an
  // unaligned half/word access is rounded down to its natural boundary.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_B:    byte_en = 4'b0001 << a;
      SZ_H:    byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_B:    store_lanes = {4{d[7:0]}};
      SZ_H:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_H:    misaligned = a[0];
      SZ_W:    misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data alignment.
// Selects the byte/halfword lane addressed by addr_lo_i out of the bus word
// and sign- or zero-extends it according to the RV32I load funct3.
// Ports:
//   rdata_i   [31:0] raw word returned by data memory
//   addr_lo_i [1:0]  byte offset of the access
//   funct3_i  [2:0]  LB/LH/LW/LBU/LHU encoding
//   data_o    [31:0] aligned, extended load result (0 for non-load codes)
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select: byte by full offset, halfword by offset bit 1 only
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    case (addr_lo_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = 8'd0;
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
  end

  // Extension to 32 bits according to width and signedness
  always_comb begin
    data_o = 32'd0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
      F3_BU:   data_o = {24'd0, byte_s};
      F3_H:    data_o = {{16{half_s[15]}}, half_s};
      F3_HU:   data_o = {16'd0, half_s};
      F3_W:    data_o = rdata_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access pipeline stage.
// Executes loads/stores held in the M pipeline register over a
// req/gnt/rvalid data bus, stalls upstream while a transaction is open and
// emits one W_valid pulse per completed access.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN -- when defined,
// misaligned half/word accesses fault with cause 1 instead of being
// rounded down to an aligned access.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   M_valid/M_mem_read/M_mem_write/M_funct3/M_alu_out/M_rs2_data
//                            instruction in the M register
//   M_stall                  upstream hold request (combinational)
//   W_valid/W_load_data      completion pulse and aligned load result
//   M_fault/M_fault_cause    registered fault pulse and its cause
//   dm_req/dm_we/dm_addr/dm_be/dm_wdata, dm_gnt/dm_rvalid/dm_rdata
//                            data-memory bus
// Parameter BUS_TIMEOUT: cycles spent in REQ+WAIT before an abort (1..65535).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_valid,
  input  logic        M_mem_read,
  input  logic        M_mem_write,
  input  logic [2:0]  M_funct3,
  input  logic [31:0] M_alu_out,
  input  logic [31:0] M_rs2_data,
  output logic        M_stall,
  output logic        W_valid,
  output logic [31:0] W_load_data,
  output logic        M_fault,
  output logic [1:0]  M_fault_cause,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  localparam logic [15:0] TO_LAST = 16'(BUS_TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;

  logic        dm_req_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [3:0]  dm_be_q;
  logic [31:0] dm_wdata_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_alo_q;

  logic        w_valid_q;
  logic [31:0] w_data_q, w_data_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;

  logic        mem_op_s;
  logic        is_store_s;
  logic        f3_legal_s;
  logic        misalign_s;
  logic        timeout_s;
  logic        accept_s;
  logic        done_s;
  logic        stall_s;
  logic [31:0] ld_data_s;

  // Decode of the instruction currently presented by the M register
  always_comb begin
    mem_op_s   = M_valid & (M_mem_read | M_mem_write);
    // Both read and write set is executed as a store.
    is_store_s = M_mem_write;
    case (M_funct3)
      F3_B, F3_H, F3_W: f3_legal_s = 1'b1;
      F3_BU, F3_HU:     f3_legal_s = ~is_store_s;
      default:          f3_legal_s = 1'b0;
    endcase
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    misalign_s = misaligned(M_funct3[1:0], M_alu_out[1:0]);
`else
    misalign_s = 1'b0;
`endif
  end

  // Abort fires on the BUS_TIMEOUT-th cycle spent in REQ/WAIT.
  assign timeout_s = (cnt_q == TO_LAST);

  // Transaction FSM: next state, counter, completion/fault and stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    done_s   = 1'b0;
    fault_d  = 1'b0;
    cause_d  = CAUSE_NONE;
    stall_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (mem_op_s) begin
          if (!f3_legal_s) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (misalign_s) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            accept_s = 1'b1;
            stall_s  = 1'b1;
            state_d  = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d   = cnt_q + 16'd1;
        stall_s = 1'b1;
        if (timeout_s) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else if (dm_gnt) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response in the last allowed cycle still completes normally.
        if (dm_rvalid) begin
          done_s  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_s) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          stall_s = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Write-back data: stores report zero, loads the aligned word
  always_comb begin
    if (done_s && !dm_we_q) begin
      w_data_d = ld_data_s;
    end else begin
      w_data_d = 32'd0;
    end
  end

  mem_load_align u_load_align (
    .rdata_i   (dm_rdata),
    .addr_lo_i (ld_alo_q),
    .funct3_i  (ld_f3_q),
    .data_o    (ld_data_s)
  );

  // State, timeout counter and bus request flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 16'd0;
      dm_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dm_req_q <= (state_d == S_REQ);
    end
  end

  // Bus attributes captured at accept and held until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'd0;
      dm_be_q    <= 4'd0;
      dm_wdata_q <= 32'd0;
      ld_f3_q    <= 3'd0;
      ld_alo_q   <= 2'd0;
    end else if (accept_s) begin
      dm_we_q    <= is_store_s;
      dm_addr_q  <= {M_alu_out[31:2], 2'b00};
      dm_be_q    <= byte_en(M_funct3[1:0], M_alu_out[1:0]);
      dm_wdata_q <= store_lanes(M_funct3[1:0], M_rs2_data);
      ld_f3_q    <= M_funct3;
      ld_alo_q   <= M_alu_out[1:0];
    end
  end

  // Completion and fault pulses towards write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid_q <= 1'b0;
      w_data_q  <= 32'd0;
      fault_q   <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      w_valid_q <= done_s;
      w_data_q  <= w_data_d;
      fault_q   <= fault_d;
      cause_q   <= cause_d;
    end
  end

  // Stall is forced low while reset is asserted.
  assign M_stall       = stall_s & ~rst;
  assign W_valid       = w_valid_q;
  assign W_load_data   = w_data_q;
  assign M_fault       = fault_q;
  assign M_fault_cause = cause_q;
  assign dm_req        = dm_req_q;
  assign dm_we         = dm_we_q;
  assign dm_addr       = dm_addr_q;
  assign dm_be         = dm_be_q;
  assign dm_wdata      = dm_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (BUS_TIMEOUT = 8).
// Table of load/store vectors plus hand-written reset, timeout and
// late-response sequences; expected completions go through a scoreboard.
module tb_mem_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid, M_mem_read, M_mem_write;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_out, M_rs2_data;
  logic        M_stall, W_valid, M_fault;
  logic [31:0] W_load_data;
  logic [1:0]  M_fault_cause;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .M_valid(M_valid), .M_mem_read(M_mem_read), .M_mem_write(M_mem_write),
    .M_funct3(M_funct3), .M_alu_out(M_alu_out), .M_rs2_data(M_rs2_data),
    .M_stall(M_stall), .W_valid(W_valid), .W_load_data(W_load_data),
    .M_fault(M_fault), .M_fault_cause(M_fault_cause),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata)
  );

  // kind: 0 bus access completes, 1 fault without bus op,
  //       2 no effect, 3 bus access that times out
  typedef struct {
    int          kind;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          gw;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] edata;
    logic [1:0]  ecause;
  } vec_t;

  typedef struct {
    bit          is_fault;
    logic [1:0]  cause;
    logic [31:0] data;
  } sb_t;

  sb_t  exp_q[$];
  vec_t vecs[$];

  function automatic vec_t mk(int kind, logic rd, logic wr, logic [2:0] f3,
                              logic [31:0] addr, logic [31:0] rs2, logic [31:0] rdata,
                              int gw, logic [31:0] eaddr, logic [3:0] ebe,
                              logic [31:0] ewd, logic [31:0] edata, logic [1:0] ecause);
    vec_t v;
    v.kind = kind; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
    v.rdata = rdata; v.gw = gw; v.eaddr = eaddr; v.ebe = ebe; v.ewd = ewd;
    v.edata = edata; v.ecause = ecause;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    M_valid = 1'b0; M_mem_read = 1'b0; M_mem_write = 1'b0;
  endtask

  task automatic run_op(input string nm, input vec_t v);
    int lat, stall_cnt, req_cycles, limit, exp_lat, exp_stall;
    bit gnt_prev, prev_stall, done, inflight;
    sb_t e;
    case (v.kind)
      0: begin exp_lat = 3 + v.gw; exp_stall = 2 + v.gw; end
      1: begin exp_lat = 1; exp_stall = 0; end
      3: begin exp_lat = TO + 1; exp_stall = TO + 1; end
      default: begin exp_lat = 0; exp_stall = 0; end
    endcase
    if (v.kind != 2) begin
      e.is_fault = (v.kind == 1 || v.kind == 3);
      e.cause    = v.ecause;
      e.data     = v.edata;
      exp_q.push_back(e);
    end
    limit = (v.kind == 2) ? 4 : 40;
    @(negedge clk);
    M_valid = 1'b1; M_mem_read = v.rd; M_mem_write = v.wr;
    M_funct3 = v.f3; M_alu_out = v.addr; M_rs2_data = v.rs2;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    req_cycles = 0; gnt_prev = 1'b0; done = 1'b0; inflight = 1'b0;
    stall_cnt = 0; lat = 0;
    #1;
    prev_stall = M_stall;
    if (prev_stall) stall_cnt++;
    while (!done && lat < limit) begin
      @(negedge clk);
      lat++;
      chk({nm, "_wv_and_fault"}, {31'd0, W_valid & M_fault}, 32'd0);
      if (W_valid || M_fault) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          chk({nm, "_unexpected_event"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({nm, "_fault"}, {31'd0, M_fault}, {31'd0, e.is_fault});
          if (e.is_fault) chk({nm, "_cause"}, {30'd0, M_fault_cause}, {30'd0, e.cause});
          else            chk({nm, "_data"}, W_load_data, e.data);
        end
        chk({nm, "_latency"}, lat, exp_lat);
      end
      if (v.kind == 0 || v.kind == 3) begin
        if (dm_req || inflight) begin
          chk({nm, "_addr"}, dm_addr, v.eaddr);
          chk({nm, "_be"}, {28'd0, dm_be}, {28'd0, v.ebe});
          chk({nm, "_we"}, {31'd0, dm_we}, {31'd0, v.wr});
          if (v.wr) chk({nm, "_wdata"}, dm_wdata, v.ewd);
        end
      end else begin
        chk({nm, "_no_req"}, {31'd0, dm_req}, 32'd0);
      end
      // memory responder: grant after gw request cycles, respond next cycle
      dm_rvalid = gnt_prev;
      dm_rdata  = gnt_prev ? v.rdata : 32'd0;
      if (dm_rvalid) inflight = 1'b0;
      if (dm_req) begin
        req_cycles++;
        dm_gnt = (v.kind != 3) && (req_cycles > v.gw);
      end else begin
        dm_gnt = 1'b0;
      end
      if (dm_gnt) inflight = 1'b1;
      gnt_prev = dm_gnt;
      // upstream advances once a cycle ended without stall, or on a fault
      if (!prev_stall || done) idle_inputs();
      #1;
      prev_stall = M_stall;
      if (prev_stall) stall_cnt++;
    end
    chk({nm, "_event_seen"}, {31'd0, done}, (v.kind != 2) ? 32'd1 : 32'd0);
    chk({nm, "_stall_cycles"}, stall_cnt, exp_stall);
    idle_inputs();
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    repeat (2) begin
      @(negedge clk);
      chk({nm, "_post_wvalid"}, {31'd0, W_valid}, 32'd0);
      chk({nm, "_post_fault"}, {31'd0, M_fault}, 32'd0);
      chk({nm, "_post_cause"}, {30'd0, M_fault_cause}, 32'd0);
      chk({nm, "_post_req"}, {31'd0, dm_req}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- vector table ----------------
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 2'd0));
    vecs.push_back(mk(0, 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 2'd0));
    vecs.push_back(mk(0, 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 2'd0));
    vecs.push_back(mk(0, 1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b1100, 32'h0, 32'h000080FF, 2'd0));
    vecs.push_back(mk(0, 1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF80FF, 2'd0));
    vecs.push_back(mk(0, 1, 0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 0, 32'h100, 4'b0010, 32'h0, 32'h00000012, 2'd0));
    vecs.push_back(mk(0, 1, 0, 3'b100, 32'h102, 32'h0, 32'h80FF1234, 1, 32'h100, 4'b0100, 32'h0, 32'h000000FF, 2'd0));
    vecs.push_back(mk(0, 0, 1, 3'b000, 32'h201, 32'hAB, 32'h0, 0, 32'h200, 4'b0010, 32'hABABABAB, 32'h0, 2'd0));
    vecs.push_back(mk(0, 0, 1, 3'b001, 32'h202, 32'h1234CAFE, 32'h0, 0, 32'h200, 4'b1100, 32'hCAFECAFE, 32'h0, 2'd0));
    vecs.push_back(mk(0, 0, 1, 3'b010, 32'h300, 32'h12345678, 32'h0, 2, 32'h300, 4'b1111, 32'h12345678, 32'h0, 2'd0));
    vecs.push_back(mk(0, 1, 1, 3'b010, 32'h010, 32'h5A5A0001, 32'h0, 0, 32'h010, 4'b1111, 32'h5A5A0001, 32'h0, 2'd0));
    vecs.push_back(mk(1, 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd3));
    vecs.push_back(mk(1, 0, 1, 3'b100, 32'h100, 32'h77, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd3));
    vecs.push_back(mk(1, 1, 0, 3'b110, 32'h104, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd3));
    vecs.push_back(mk(2, 0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd0));
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd1));
    vecs.push_back(mk(1, 1, 0, 3'b001, 32'h101, 32'h0, 32'h12348001, 0, 32'h0, 4'b0, 32'h0, 32'h0, 2'd1));
`else
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 32'h100, 4'b1111, 32'h0, 32'hCAFEF00D, 2'd0));
    vecs.push_back(mk(0, 1, 0, 3'b001, 32'h101, 32'h0, 32'h12348001, 0, 32'h100, 4'b0011, 32'h0, 32'hFFFF8001, 2'd0));
`endif
    // grant withheld for 3 request cycles
    vecs.push_back(mk(0, 1, 0, 3'b010, 32'h040, 32'h0, 32'h0BADF00D, 3, 32'h040, 4'b1111, 32'h0, 32'h0BADF00D, 2'd0));

    // ---------------- reset state ----------------
    rst = 1'b1;
    M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0;
    M_funct3 = 3'b010; M_alu_out = 32'h100; M_rs2_data = 32'h0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, M_stall}, 32'd0);
    chk("rst_req", {31'd0, dm_req}, 32'd0);
    chk("rst_we", {31'd0, dm_we}, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_be", {28'd0, dm_be}, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_wvalid", {31'd0, W_valid}, 32'd0);
    chk("rst_wdata_out", W_load_data, 32'd0);
    chk("rst_fault", {31'd0, M_fault}, 32'd0);
    chk("rst_cause", {30'd0, M_fault_cause}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    foreach (vecs[i]) run_op($sformatf("v%0d", i), vecs[i]);

    // ---------------- timeout, late response, recovery ----------------
    run_op("timeout", mk(3, 1, 0, 3'b010, 32'h600, 32'h0, 32'h0, 0, 32'h600, 4'b1111, 32'h0, 32'h0, 2'd2));
    @(negedge clk);
    dm_rvalid = 1'b1; dm_rdata = 32'h55AA55AA;
    @(negedge clk);
    dm_rvalid = 1'b0; dm_rdata = 32'h0;
    chk("late_rvalid_wvalid", {31'd0, W_valid}, 32'd0);
    chk("late_rvalid_fault", {31'd0, M_fault}, 32'd0);
    run_op("after_timeout", mk(0, 1, 0, 3'b010, 32'h700, 32'h0, 32'h13579BDF, 0, 32'h700, 4'b1111, 32'h0, 32'h13579BDF, 2'd0));

    // ---------------- reset during an open transaction ----------------
    @(negedge clk);
    M_valid = 1'b1; M_mem_read = 1'b1; M_mem_write = 1'b0;
    M_funct3 = 3'b010; M_alu_out = 32'h500;
    dm_gnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_req_before", {31'd0, dm_req}, 32'd1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    chk("midrst_req", {31'd0, dm_req}, 32'd0);
    chk("midrst_stall", {31'd0, M_stall}, 32'd0);
    chk("midrst_addr", dm_addr, 32'd0);
    rst = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 32'h1;
    @(negedge clk);
    dm_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_wvalid", {31'd0, W_valid}, 32'd0);
      chk("midrst_fault", {31'd0, M_fault}, 32'd0);
    end
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I pipeline: consumes the registered ALU result (effective address) and rs2 store data held in the M pipeline register, and executes loads and stores over a req/gnt/rvalid data-memory bus. It forms byte enables and store lanes, aligns and sign-extends load data, and stalls the upstream pipeline while a bus transaction is outstanding. It delivers one load-data/valid pulse per completed access to the write-back stage.

## Interface
- BUS_TIMEOUT, 255: cycles in REQ+WAIT before the transaction is aborted with a timeout fault; 1..65535.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- M_valid  in  1  M-stage instruction valid.
- M_mem_read  in  1  instruction is a load.
- M_mem_write  in  1  instruction is a store.
- M_funct3  in  3  access width and sign (RV32I encoding).
- M_alu_out  in  32  effective byte address.
- M_rs2_data  in  32  store data, LSBs significant.
- M_stall  out  1  upstream must hold all M_* inputs stable.
- W_valid  out  1  one-cycle pulse: access completed.
- W_load_data  out  32  aligned, extended load result; stores give 0.
- M_fault  out  1  one-cycle fault pulse.
- M_fault_cause  out  2  1 misaligned, 2 bus timeout, 3 illegal funct3; 0 when no fault.
- dm_req  out  1  bus request, held until dm_gnt.
- dm_we  out  1  1 store, 0 load.
- dm_addr  out  32  word address, bits [1:0] = 0.
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_gnt  in  1  request accepted this cycle.
- dm_rvalid  in  1  response (load data or store ack); earliest one cycle after dm_gnt.
- dm_rdata  in  32  load word.

## Operation
- Memory op = M_valid & (M_mem_read | M_mem_write). Both set: treat as store.
- FSM IDLE -> REQ -> WAIT -> IDLE.
- IDLE: on a legal memory op, register dm_addr, dm_we, dm_be, dm_wdata and the load controls; next state REQ. Non-memory ops have no effect.
- REQ: dm_req=1. On dm_gnt, go to WAIT.
- WAIT: on dm_rvalid, go to IDLE. W_valid and W_load_data are registered on that edge.
- funct3 legal values: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are illegal for stores.
- Illegal funct3: no bus op. M_fault with cause 3 on the next cycle. No stall.
- Byte enables: B = 0001 << a[1:0]; H = 0011 << {a[1],1'b0}; W = 1111.
- Store data: byte replicated x4, half x2, word as is.
- Loads: select lane by a[1:0], then sign-extend (B/H) or zero-extend (BU/HU).
- Timeout counter: cleared on leaving IDLE, increments each cycle in REQ/WAIT. On reaching BUS_TIMEOUT: abort to IDLE, dm_req=0, M_fault with cause 2, no W_valid. A late dm_rvalid arriving in IDLE is ignored.
- rst: state IDLE, counter 0. All outputs 0: dm_*, W_valid, W_load_data, M_fault, M_fault_cause, M_stall. An in-flight transaction is dropped; the memory is reset on the same rst.

## Timing
- M_stall = (IDLE & legal mem op & not misaligned-trapped) | REQ | (WAIT & !dm_rvalid & !timeout). This is combinational from state and inputs.
- Stall is low in the dm_rvalid cycle. Upstream advances at that edge.
- Minimum load latency, with accept at cycle T, dm_gnt at T+1 and dm_rvalid at T+2: W_valid at T+3.
- dm_req rises the cycle after accept. dm_addr, dm_we, dm_be and dm_wdata are stable while dm_req=1 and until dm_rvalid.
- M_fault/M_fault_cause are registered and appear one cycle after the detecting cycle.
- W_valid and M_fault are never asserted in the same cycle.

## Configuration
- MEM_STAGE_MISALIGN_TRAP_EN defined: misaligned accesses (H with a[0]=1; W with a[1:0]!=0) issue no bus op and raise M_fault with cause 1 the next cycle, with no stall.
- Not defined: low address bits below the access width are ignored. An aligned access is performed, and cause 1 is never produced.

## Structure
- Package mem_stage_pkg holds:
  - state enum (IDLE/REQ/WAIT);
  - funct3 width constants;
  - fault cause constants (NONE=0, MISALIGN=1, TIMEOUT=2, ILLEGAL=3).
- One combinational sub-module, mem_load_align: inputs rdata, a[1:0] and funct3; output is the extended 32-bit result.

## Test plan
- LW at 0x100, dm_gnt same cycle as dm_req, dm_rdata=0xDEADBEEF the next cycle -> W_valid pulse with W_load_data=0xDEADBEEF; M_stall high for exactly 2 cycles.
- LB at 0x103 with rdata 0x80FF_1234 -> W_load_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- SB at 0x201 with rs2=0x000000AB -> dm_be=0010, dm_wdata=0xABABABAB, dm_we=1, dm_addr=0x200.
- Hold dm_gnt low for 3 cycles -> dm_req and address held stable, M_stall high throughout; completion follows normally.
- BUS_TIMEOUT=8, dm_gnt never asserted -> abort after 8 cycles, M_fault=1 with cause 2, no W_valid; the next load completes normally.
- LW at 0x102 -> with the macro: no dm_req, M_fault with cause 1. Without the macro: dm_addr=0x100, dm_be=1111.
